errbit_frame_counter: RTL and testbench

//  Parametrised error-bit counter for the decoder simulation logger.
//  - Takes each decoded frame as ROW_CHUNK_NUM chunks of N hard bits, one chunk per valid cycle.
//  - Per frame: popcounts the error bits, accumulates them, and reports the frame error count with a stretched done pulse.
//  - Keeps saturating BER/FER statistics: total error bits, errored frames and frames seen.

---
 rtl/errbit_cnt_pkg.sv | 39 +++
 rtl/errbit_popcount_lane.sv | 24 ++
 rtl/errbit_frame_counter.sv | 207 ++++++++++++++++++++
 tb/tb_errbit_frame_counter.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/errbit_cnt_pkg.sv
// ============================================================================
// errbit_cnt_pkg : shared sizing helpers and saturating add for the counter
// Rev 1.0
// ============================================================================
`default_nettype none

package errbit_cnt_pkg;

  localparam int N_DEF             = 850;
  localparam int ROW_CHUNK_NUM_DEF = 9;
  localparam int LANE_W_DEF        = 128;

  // NUM_LANES for a given chunk/lane width
  function automatic int calc_num_lanes(input int n, input int lane_w);
    return (n + lane_w - 1) / lane_w;
  endfunction

  // Bits needed to hold 0..max_val (LANE_CNT_W, CHUNK_ERR_W, FRAME_ERR_W)
  function automatic int calc_cnt_w(input int max_val);
    return $clog2(max_val + 1);
  endfunction

  // a + b clamped to the all-ones value of a w-bit field
  function automatic logic [63:0] sat_add(input logic [63:0] a,
                                          input logic [63:0] b,
                                          input int          w);
    logic [63:0] max_val;
    logic [64:0] sum;
    max_val = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    sum     = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, max_val}) begin
      return max_val;
    end
    return sum[63:0];
  endfunction

endpackage

`default_nettype wire

// File: rtl/errbit_popcount_lane.sv
// ============================================================================
// errbit_popcount_lane : combinational popcount of one LANE_W-bit lane
// Rev 1.0
// ============================================================================
`default_nettype none

module errbit_popcount_lane #(
  parameter int LANE_W = 128,
  parameter int CNT_W  = 8
) (
  input  logic [LANE_W-1:0] i_bits,
  output logic [CNT_W-1:0]  o_count
);

  always_comb begin
    o_count = '0;
    for (int i = 0; i < LANE_W; i++) begin
      o_count = o_count + CNT_W'(i_bits[i]);
    end
  end

endmodule

`default_nettype wire

// File: rtl/errbit_frame_counter.sv
// ============================================================================
// errbit_frame_counter : per-frame error-bit popcount with saturating BER/FER
//                        statistics and a stretched frame_done pulse
// Rev 1.0
// ============================================================================
`default_nettype none

module errbit_frame_counter
  import errbit_cnt_pkg::*;
#(
  parameter int N             = N_DEF,
  parameter int ROW_CHUNK_NUM = ROW_CHUNK_NUM_DEF,
  parameter int LANE_W        = LANE_W_DEF,
  parameter int ERR_POLARITY  = 0,
  parameter int SYN_LATENCY   = 2,
  parameter int TOTAL_W       = 40,
  parameter int FRAME_W       = 32
) (
  input  logic                                    eval_clk,
  input  logic                                    rstn,
  input  logic                                    clear,
  input  logic                                    chunk_valid,
  input  logic                                    chunk_last,
  input  logic [N-1:0]                            hard_chunk,
  output logic                                    busy,
  output logic                                    frame_done,
  output logic [$clog2(N*ROW_CHUNK_NUM+1)-1:0]    frame_err_count,
  output logic                                    len_err,
  output logic [TOTAL_W-1:0]                      total_err_bits,
  output logic [FRAME_W-1:0]                      err_frame_cnt,
  output logic [FRAME_W-1:0]                      frame_cnt
);

  localparam int   NUM_LANES   = calc_num_lanes(N, LANE_W);
  localparam int   PAD_W       = NUM_LANES * LANE_W;
  localparam int   LANE_CNT_W  = calc_cnt_w(LANE_W);
  localparam int   ONES_W      = calc_cnt_w(PAD_W);
  localparam int   CHUNK_ERR_W = calc_cnt_w(N);
  localparam int   FRAME_ERR_W = calc_cnt_w(N * ROW_CHUNK_NUM);
  localparam int   CHUNK_CNT_W = calc_cnt_w(ROW_CHUNK_NUM);
  localparam int   DONE_W      = calc_cnt_w(SYN_LATENCY);
  localparam logic PAD_BIT     = (ERR_POLARITY == 0);

  logic [N-1:0]             r_s0_data;
  logic                     r_s0_valid, r_s0_last;
  logic [LANE_CNT_W-1:0]    r_s1_cnt [NUM_LANES];
  logic                     r_s1_valid, r_s1_last;
  logic [ONES_W-1:0]        r_s2_ones;
  logic                     r_s2_valid, r_s2_last;
  logic [CHUNK_ERR_W-1:0]   r_s3_err;
  logic                     r_s3_valid, r_s3_last;
  logic [FRAME_ERR_W-1:0]   r_acc;
  logic                     r_acc_load, r_acc_done;
  logic [FRAME_ERR_W-1:0]   r_frame_err;
  logic [DONE_W-1:0]        r_done_cnt;
  logic [CHUNK_CNT_W-1:0]   r_chunk_cnt;
  logic                     r_in_frame, r_len_err;
  logic [TOTAL_W-1:0]       r_total;
  logic [FRAME_W-1:0]       r_err_frames, r_frames;

  logic [PAD_W-1:0]         w_padded;
  logic [LANE_CNT_W-1:0]    w_lane_cnt [NUM_LANES];
  logic [ONES_W-1:0]        w_ones_sum;
  logic [CHUNK_ERR_W-1:0]   w_chunk_err;
  logic [FRAME_ERR_W-1:0]   w_acc_next;
  logic [CHUNK_CNT_W-1:0]   w_chunk_cnt_inc;
  logic                     w_len_mismatch;

  // Pad lanes past N with non-error bits; S3 then subtracts from PAD_W so
  // the pad ones cancel out for ERR_POLARITY=0.
  always_comb begin
    w_padded         = PAD_BIT ? {PAD_W{1'b1}} : {PAD_W{1'b0}};
    w_padded[N-1:0]  = r_s0_data;
  end

  generate
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
      errbit_popcount_lane #(
        .LANE_W (LANE_W),
        .CNT_W  (LANE_CNT_W)
      ) u_lane (
        .i_bits  (w_padded[l*LANE_W +: LANE_W]),
        .o_count (w_lane_cnt[l])
      );
    end
  endgenerate

  always_comb begin
    w_ones_sum = '0;
    for (int l = 0; l < NUM_LANES; l++) begin
      w_ones_sum = w_ones_sum + ONES_W'(r_s1_cnt[l]);
    end
  end

  always_comb begin
    if (ERR_POLARITY == 0) begin
      w_chunk_err = CHUNK_ERR_W'(ONES_W'(PAD_W) - r_s2_ones);
    end else begin
      w_chunk_err = CHUNK_ERR_W'(r_s2_ones);
    end
  end

  assign w_acc_next      = r_acc_load ? FRAME_ERR_W'(r_s3_err)
                                      : r_acc + FRAME_ERR_W'(r_s3_err);
  assign w_chunk_cnt_inc = r_chunk_cnt + 1'b1;
  assign w_len_mismatch  = chunk_valid && chunk_last &&
                           (w_chunk_cnt_inc != CHUNK_CNT_W'(ROW_CHUNK_NUM));

  // Datapath pipeline S0..S4; every stage advances each cycle
  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      r_s0_data  <= '0;
      r_s0_valid <= 1'b0;
      r_s0_last  <= 1'b0;
      for (int l = 0; l < NUM_LANES; l++) r_s1_cnt[l] <= '0;
      r_s1_valid <= 1'b0;
      r_s1_last  <= 1'b0;
      r_s2_ones  <= '0;
      r_s2_valid <= 1'b0;
      r_s2_last  <= 1'b0;
      r_s3_err   <= '0;
      r_s3_valid <= 1'b0;
      r_s3_last  <= 1'b0;
      r_acc      <= '0;
      r_acc_load <= 1'b1;
      r_acc_done <= 1'b0;
    end else begin
      r_s0_data  <= hard_chunk;
      r_s0_valid <= chunk_valid;
      r_s0_last  <= chunk_valid && chunk_last;
      for (int l = 0; l < NUM_LANES; l++) r_s1_cnt[l] <= w_lane_cnt[l];
      r_s1_valid <= r_s0_valid;
      r_s1_last  <= r_s0_last;
      r_s2_ones  <= w_ones_sum;
      r_s2_valid <= r_s1_valid;
      r_s2_last  <= r_s1_last;
      r_s3_err   <= w_chunk_err;
      r_s3_valid <= r_s2_valid;
      r_s3_last  <= r_s2_last;
      if (r_s3_valid) begin
        r_acc      <= w_acc_next;
        r_acc_load <= r_s3_last;
      end
      r_acc_done <= r_s3_valid && r_s3_last;
    end
  end

  // Frame completion: result register, done stretcher and statistics
  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      r_frame_err  <= '0;
      r_done_cnt   <= '0;
      r_total      <= '0;
      r_err_frames <= '0;
      r_frames     <= '0;
    end else begin
      if (r_acc_done) begin
        r_frame_err <= r_acc;
        r_done_cnt  <= DONE_W'(SYN_LATENCY);
      end else if (r_done_cnt != '0) begin
        r_done_cnt  <= r_done_cnt - 1'b1;
      end

      if (clear) begin
        r_total      <= '0;
        r_err_frames <= '0;
        r_frames     <= '0;
      end else if (r_acc_done) begin
        r_total      <= TOTAL_W'(sat_add(64'(r_total), 64'(r_acc), TOTAL_W));
        r_err_frames <= FRAME_W'(sat_add(64'(r_err_frames),
                                         64'(r_acc != '0), FRAME_W));
        r_frames     <= FRAME_W'(sat_add(64'(r_frames), 64'd1, FRAME_W));
      end
    end
  end

  // Input-side frame tracking: chunk count check and busy window
  always_ff @(posedge eval_clk or negedge rstn) begin
    if (!rstn) begin
      r_chunk_cnt <= '0;
      r_in_frame  <= 1'b0;
      r_len_err   <= 1'b0;
    end else begin
      if (chunk_valid) begin
        r_chunk_cnt <= chunk_last ? '0 : w_chunk_cnt_inc;
        r_in_frame  <= !chunk_last;
      end
      if (clear) begin
        r_len_err <= 1'b0;
      end else if (w_len_mismatch) begin
        r_len_err <= 1'b1;
      end
    end
  end

  assign busy            = r_in_frame || r_s0_valid || r_s1_valid ||
                           r_s2_valid || r_s3_valid || r_acc_done;
  assign frame_done      = (r_done_cnt != '0);
  assign frame_err_count = r_frame_err;
  assign len_err         = r_len_err;
  assign total_err_bits  = r_total;
  assign err_frame_cnt   = r_err_frames;
  assign frame_cnt       = r_frames;

endmodule

`default_nettype wire

// File: tb/tb_errbit_frame_counter.sv
// ============================================================================
// tb_errbit_frame_counter : directed self-checking bench for errbit_frame_counter
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_errbit_frame_counter;

  localparam int N   = 850;
  localparam int FEW = 13;

  logic           eval_clk = 1'b0;
  logic           rstn = 1'b0, clear = 1'b0;
  logic           chunk_valid = 1'b0, chunk_last = 1'b0;
  logic [N-1:0]   hard_chunk = '0;

  logic           busy, frame_done, len_err;
  logic [FEW-1:0] frame_err_count;
  logic [39:0]    total_err_bits;
  logic [31:0]    err_frame_cnt, frame_cnt;

  logic           busy8, frame_done8, len_err8;
  logic [FEW-1:0] frame_err_count8;
  logic [7:0]     total_err_bits8;
  logic [31:0]    err_frame_cnt8, frame_cnt8;

  int n_checks = 0;
  int n_fail   = 0;
  int pos_tab [4] = '{0, 849, 767, 768};

  errbit_frame_counter dut (
    .eval_clk(eval_clk), .rstn(rstn), .clear(clear),
    .chunk_valid(chunk_valid), .chunk_last(chunk_last), .hard_chunk(hard_chunk),
    .busy(busy), .frame_done(frame_done), .frame_err_count(frame_err_count),
    .len_err(len_err), .total_err_bits(total_err_bits),
    .err_frame_cnt(err_frame_cnt), .frame_cnt(frame_cnt)
  );

  errbit_frame_counter #(.TOTAL_W(8)) dut8 (
    .eval_clk(eval_clk), .rstn(rstn), .clear(clear),
    .chunk_valid(chunk_valid), .chunk_last(chunk_last), .hard_chunk(hard_chunk),
    .busy(busy8), .frame_done(frame_done8), .frame_err_count(frame_err_count8),
    .len_err(len_err8), .total_err_bits(total_err_bits8),
    .err_frame_cnt(err_frame_cnt8), .frame_cnt(frame_cnt8)
  );

  always #5 eval_clk = ~eval_clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(negedge eval_clk);
  endtask

  task automatic send(input logic [N-1:0] d, input logic last);
    chunk_valid = 1'b1;
    chunk_last  = last;
    hard_chunk  = d;
    cyc();
  endtask

  task automatic idle();
    chunk_valid = 1'b0;
    chunk_last  = 1'b0;
    hard_chunk  = '0;
    cyc();
  endtask

  // All-ones chunk with the low k bits zero (k errors at ERR_POLARITY=0)
  function automatic logic [N-1:0] mk(input int k);
    logic [N-1:0] c;
    c = '1;
    for (int i = 0; i < k; i++) c[i] = 1'b0;
    return c;
  endfunction

  function automatic logic [N-1:0] zero_at(input int p);
    logic [N-1:0] c;
    c = '1;
    c[p] = 1'b0;
    return c;
  endfunction

  initial begin
    // Reset state
    repeat (3) cyc();
    check("rst_busy", 64'(busy), 0);
    check("rst_done", 64'(frame_done), 0);
    check("rst_err", 64'(frame_err_count), 0);
    check("rst_len", 64'(len_err), 0);
    check("rst_total", 64'(total_err_bits), 0);
    check("rst_errfr", 64'(err_frame_cnt), 0);
    check("rst_frames", 64'(frame_cnt), 0);
    rstn = 1'b1;
    cyc();

    // 1: clean frame, latency and stretch width
    for (int i = 0; i < 9; i++) send(mk(0), (i == 8));
    check("t1_busy_inflight", 64'(busy), 1);
    repeat (4) idle();
    check("t1_done_T4", 64'(frame_done), 0);
    idle();
    check("t1_done_T5", 64'(frame_done), 1);
    check("t1_err", 64'(frame_err_count), 0);
    check("t1_frames", 64'(frame_cnt), 1);
    check("t1_errfr", 64'(err_frame_cnt), 0);
    check("t1_busy_idle", 64'(busy), 0);
    idle();
    check("t1_done_T6", 64'(frame_done), 1);
    idle();
    check("t1_done_T7", 64'(frame_done), 0);

    // 2: one error per chunk at edge positions
    for (int i = 0; i < 9; i++) send(zero_at(pos_tab[i % 4]), (i == 8));
    repeat (5) idle();
    check("t2_err", 64'(frame_err_count), 9);
    check("t2_total", 64'(total_err_bits), 9);
    check("t2_errfr", 64'(err_frame_cnt), 1);
    check("t2_frames", 64'(frame_cnt), 2);
    repeat (3) idle();

    // 3: all-error frame then clean frame, back to back
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check("t3_cleared", 64'(frame_cnt), 0);
    for (int k = 0; k < 18; k++) begin
      send((k < 9) ? mk(0) ^ '1 : mk(0), (k == 8) || (k == 17));
      if (k == 13) begin
        check("t3_done_a", 64'(frame_done), 1);
        check("t3_err_a", 64'(frame_err_count), 7650);
      end
      if (k == 15) check("t3_done_a_end", 64'(frame_done), 0);
    end
    repeat (5) idle();
    check("t3_done_b", 64'(frame_done), 1);
    check("t3_err_b", 64'(frame_err_count), 0);
    check("t3_total", 64'(total_err_bits), 7650);
    check("t3_frames", 64'(frame_cnt), 2);
    check("t3_errfr", 64'(err_frame_cnt), 1);
    check("t3_sat8", 64'(total_err_bits8), 255);
    repeat (3) idle();

    // 4: short frame (8 chunks) then 1-chunk frame; stretch restart, len_err
    for (int i = 0; i < 8; i++) send(zero_at(i), (i == 7));
    send(mk(2), 1'b1);
    check("t4_len_set", 64'(len_err), 1);
    repeat (3) idle();
    check("t4_done_T4", 64'(frame_done), 0);
    idle();
    check("t4_done_a", 64'(frame_done), 1);
    check("t4_err_a", 64'(frame_err_count), 8);
    idle();
    check("t4_err_b", 64'(frame_err_count), 2);
    idle();
    check("t4_restart_hold", 64'(frame_done), 1);
    idle();
    check("t4_done_end", 64'(frame_done), 0);
    check("t4_frames", 64'(frame_cnt), 4);
    check("t4_total", 64'(total_err_bits), 7660);
    check("t4_errfr", 64'(err_frame_cnt), 3);
    check("t4_len_sticky", 64'(len_err), 1);
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check("t4_clr_len", 64'(len_err), 0);
    check("t4_clr_total", 64'(total_err_bits), 0);
    check("t4_clr_errfr", 64'(err_frame_cnt), 0);
    check("t4_clr_frames", 64'(frame_cnt), 0);

    // 5: clear on the completion edge wins over statistics
    for (int i = 0; i < 9; i++) send((i == 0) ? mk(5) : mk(0), (i == 8));
    repeat (4) idle();
    clear = 1'b1;
    idle();
    clear = 1'b0;
    check("t5_done", 64'(frame_done), 1);
    check("t5_err", 64'(frame_err_count), 5);
    check("t5_frames", 64'(frame_cnt), 0);
    check("t5_total", 64'(total_err_bits), 0);
    check("t5_errfr", 64'(err_frame_cnt), 0);
    repeat (3) idle();

    // 6: async reset mid-frame, then clean frames and saturation
    for (int i = 0; i < 3; i++) send(mk(7), 1'b0);
    chunk_valid = 1'b1;
    hard_chunk  = mk(7);
    rstn        = 1'b0;
    #1;
    check("t6_rst_busy", 64'(busy), 0);
    check("t6_rst_err", 64'(frame_err_count), 0);
    check("t6_rst_done", 64'(frame_done), 0);
    cyc();
    idle();
    rstn = 1'b1;
    idle();
    for (int i = 0; i < 9; i++) send((i == 0) ? mk(3) : mk(0), (i == 8));
    repeat (5) idle();
    check("t6_err", 64'(frame_err_count), 3);
    check("t6_frames", 64'(frame_cnt), 1);
    check("t6_total", 64'(total_err_bits), 3);
    check("t6_len", 64'(len_err), 0);
    check("t6_total8", 64'(total_err_bits8), 3);
    for (int i = 0; i < 9; i++) send((i == 0) ? mk(300) : mk(0), (i == 8));
    repeat (5) idle();
    check("t6_err300", 64'(frame_err_count), 300);
    check("t6_total303", 64'(total_err_bits), 303);
    check("t6_sat8", 64'(total_err_bits8), 255);
    check("t6_errfr", 64'(err_frame_cnt), 2);
    check("t6_frames2", 64'(frame_cnt), 2);
    repeat (3) idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
